// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the time-multiplexed FIR engine.
//   fir_state_e  - engine FSM states
//   acc_width()  - accumulator width: full 2N-bit product plus log2(TAPS) growth bits
//   taps_legal() - TAPS must be a power of two in 2..64; the parallel chain uses the same check
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } fir_state_e;

    function automatic int acc_width(input int n, input int taps);
        return 2 * n + $clog2(taps);
    endfunction

    function automatic bit taps_legal(input int taps);
        return (taps >= 2) && (taps <= 64) && ((taps & (taps - 1)) == 0);
    endfunction

endpackage

// File: rtl/sample_ring.sv
// sample_ring: TAPS x N circular sample history.
//   clk, rst   - clock, asynchronous active-low reset (clears history and pointer)
//   we, wdata  - write wdata at the write pointer, then advance the pointer
//   rd_off     - read offset from the newest sample (0 = newest)
//   rdata      - combinational read data
module sample_ring
    import fir_pkg::*;
#(
    parameter int N    = 32,
    parameter int TAPS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic signed [N-1:0]       wdata,
    input  logic [$clog2(TAPS)-1:0]   rd_off,
    output logic signed [N-1:0]       rdata
);

    localparam int PW = $clog2(TAPS);

    logic [PW-1:0]        wptr_q;
    logic signed [N-1:0]  mem_q [TAPS];
    logic [PW-1:0]        rd_idx;

    // wptr points at the next free slot, so the newest sample lives at wptr-1.
    // TAPS is a power of two, so the pointer width gives the modulo for free.
    assign rd_idx = wptr_q - PW'(1) - rd_off;
    assign rdata  = mem_q[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + PW'(1);
        end
    end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: FIR filter sharing one multiplier across TAPS cycles per output.
//   clk, rst              - clock, asynchronous active-low reset
//   ena                   - global enable; low freezes all state
//   x_in/x_valid/x_ready  - sample input handshake
//   coef_we/addr/data     - coefficient write port (accepted only while idle)
//   coef_err              - one-cycle pulse when a coefficient write is dropped
//   y_out/y_valid/y_ready - result output handshake (low N bits of the accumulator)
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | one tap per cycle, newest sample first (k = 0..TAPS-1)
// HOLD  | result presented on y_out until the downstream takes it
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int N    = 32,
    parameter int TAPS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic signed [N-1:0]       x_in,
    input  logic                      x_valid,
    output logic                      x_ready,
    input  logic                      coef_we,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [N-1:0]       coef_data,
    output logic                      coef_err,
    output logic signed [N-1:0]       y_out,
    output logic                      y_valid,
    input  logic                      y_ready
);

    localparam int KW    = $clog2(TAPS);
    localparam int P_W   = 2 * N;
    localparam int ACC_W = acc_width(N, TAPS);

    generate
        if (!taps_legal(TAPS)) begin : g_bad_taps
            $error("fir_mac_engine: TAPS must be a power of two in 2..64");
        end
    endgenerate

    fir_state_e              state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [N-1:0]     y_out_q, y_out_d;
    logic                    y_valid_q, y_valid_d;
    logic                    coef_err_q, coef_err_d;
    logic                    accept;
    logic                    coef_wr;

    logic signed [N-1:0]     coef_q [TAPS];
    logic signed [N-1:0]     hist_rd;
    logic signed [P_W-1:0]   hist_ext, coef_ext, prod;

    sample_ring #(
        .N    (N),
        .TAPS (TAPS)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .we     (accept),
        .wdata  (x_in),
        .rd_off (k_q),
        .rdata  (hist_rd)
    );

    // Operands are sign-extended to 2N first so the product is exact.
    assign hist_ext = P_W'(hist_rd);
    assign coef_ext = P_W'(coef_q[k_q]);
    assign prod     = hist_ext * coef_ext;

    // Gated by rst so ready is low while reset is held, high right after release.
    assign x_ready  = rst && ena && (state_q == IDLE);

    assign y_out    = y_out_q;
    assign y_valid  = y_valid_q;
    assign coef_err = coef_err_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        acc_d      = acc_q;
        y_out_d    = y_out_q;
        y_valid_d  = y_valid_q;
        coef_err_d = 1'b0;
        accept     = 1'b0;
        coef_wr    = 1'b0;

        if (ena) begin
            case (state_q)
                IDLE: begin
                    // A write in the accepting cycle lands before the first MAC read.
                    coef_wr = coef_we;
                    if (x_valid && x_ready) begin
                        accept  = 1'b1;
                        acc_d   = '0;
                        k_d     = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    coef_err_d = coef_we;
                    acc_d      = acc_q + ACC_W'(prod);
                    k_d        = k_q + KW'(1);
                    if (k_q == KW'(TAPS - 1)) begin
                        y_out_d   = acc_d[N-1:0];
                        y_valid_d = 1'b1;
                        state_d   = HOLD;
                    end
                end
                HOLD: begin
                    coef_err_d = coef_we;
                    if (y_ready) begin
                        y_valid_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            acc_q      <= '0;
            y_out_q    <= '0;
            y_valid_q  <= 1'b0;
            coef_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            y_out_q    <= y_out_d;
            y_valid_q  <= y_valid_d;
            coef_err_q <= coef_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
            end
        end else if (coef_wr) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

endmodule
